// File: rtl/screen_sequencer_pkg.sv
// screen_sequencer_pkg: screen state codes shared with every module that reads the sequencer state
package screen_sequencer_pkg;
  typedef enum logic [1:0] {
    SCREEN_IDLE  = 2'd0,
    SCREEN_START = 2'd1,
    SCREEN_PLAY  = 2'd2,
    SCREEN_OVER  = 2'd3
  } screen_t;
  localparam logic [7:0] FRAME_MAX = 8'd255;
endpackage

// File: rtl/key_edge.sv
// key_edge: registered rising-edge pulse of a synchronous level input
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);
  logic level_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: start/play/over screen sequencing with frame hold timers and prompt blink
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int START_HOLD_FRAMES = 30,
  parameter int OVER_HOLD_FRAMES  = 120,
  parameter int BLINK_HALF        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       player_fell,
  output logic       start_en,
  output logic       game_en,
  output logic       over_en,
  output logic       game_rst,
  output logic       text_blink,
  output logic [1:0] state
);
  screen_t cur, nxt;
  logic key_press;
  logic [7:0] frame_cnt;
  logic [8:0] cnt_inc;
  logic blink_hit;
  key_edge u_key_edge (
    .clk  (clk),
    .rst  (rst),
    .level(key_left | key_right),
    .press(key_press)
  );
  assign cnt_inc   = {1'b0, frame_cnt} + 9'd1;
  assign blink_hit = frame_tick && (cnt_inc % 9'(BLINK_HALF) == 9'd0);
  always_comb
    nxt = cur == SCREEN_IDLE ? SCREEN_START :
          cur == SCREEN_START && key_press && frame_cnt >= 8'(START_HOLD_FRAMES) ? SCREEN_PLAY :
          cur == SCREEN_PLAY && player_fell ? SCREEN_OVER :
          cur == SCREEN_OVER && frame_tick && frame_cnt == 8'(OVER_HOLD_FRAMES - 1) ? SCREEN_START :
          cur;
  // outputs decode the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur        <= SCREEN_IDLE;
      frame_cnt  <= '0;
      start_en   <= 1'b0;
      game_en    <= 1'b0;
      over_en    <= 1'b0;
      game_rst   <= 1'b0;
      text_blink <= 1'b0;
    end else begin
      cur        <= nxt;
      frame_cnt  <= nxt != cur ? '0 :
                    frame_tick && frame_cnt != FRAME_MAX ? frame_cnt + 8'd1 : frame_cnt;
      start_en   <= nxt == SCREEN_START;
      game_en    <= nxt == SCREEN_PLAY;
      over_en    <= nxt == SCREEN_OVER;
      game_rst   <= nxt == SCREEN_PLAY && cur != SCREEN_PLAY;
      text_blink <= nxt != SCREEN_START ? 1'b0 :
                    cur != SCREEN_START ? 1'b1 : text_blink ^ blink_hit;
    end
  assign state = cur;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: scenario tasks plus randomized run against a behavioural screen model
module tb_screen_sequencer;
  localparam int SH = 4, OH = 3, BH = 2;
  logic clk = 0, rst = 0, frame_tick = 0, key_left = 0, key_right = 0, player_fell = 0;
  logic start_en, game_en, over_en, game_rst, text_blink;
  logic [1:0] state;
  logic s_start_en, s_game_en, s_over_en, s_game_rst, s_text_blink;
  logic [1:0] s_state;
  logic [6:0] obs;
  int checks = 0, errors = 0, cycle = 0;
  bit tick_on = 0;
  int m_state, m_cnt;
  bit m_blink, m_grst, m_kq, m_press;
  always #5 clk = ~clk;
  assign obs = {state, start_en, game_en, over_en, game_rst, text_blink};
  screen_sequencer #(.START_HOLD_FRAMES(SH), .OVER_HOLD_FRAMES(OH), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_left(key_left), .key_right(key_right),
    .player_fell(player_fell), .start_en(start_en), .game_en(game_en), .over_en(over_en),
    .game_rst(game_rst), .text_blink(text_blink), .state(state)
  );
  screen_sequencer #(.START_HOLD_FRAMES(255), .OVER_HOLD_FRAMES(OH), .BLINK_HALF(BH)) dut_sat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_left(key_left), .key_right(key_right),
    .player_fell(player_fell), .start_en(s_start_en), .game_en(s_game_en), .over_en(s_over_en),
    .game_rst(s_game_rst), .text_blink(s_text_blink), .state(s_state)
  );
  // model: 0 idle, 1 start screen, 2 playing, 3 game over
  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_blink = 0; m_grst = 0; m_kq = 0; m_press = 0;
  endtask
  task automatic model_edge();
    int nxt;
    bit ka;
    ka = key_left | key_right;
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 1 && m_press && m_cnt >= SH) nxt = 2;
    else if (m_state == 2 && player_fell) nxt = 3;
    else if (m_state == 3 && frame_tick && m_cnt == OH - 1) nxt = 1;
    m_grst = (nxt == 2 && m_state != 2);
    if (nxt != 1) m_blink = 0;
    else if (m_state != 1) m_blink = 1;
    else if (frame_tick && (m_cnt + 1) % BH == 0) m_blink = !m_blink;
    if (nxt != m_state) m_cnt = 0;
    else if (frame_tick && m_cnt < 255) m_cnt = m_cnt + 1;
    m_press = ka && !m_kq;
    m_kq = ka;
    m_state = nxt;
  endtask
  function automatic logic [6:0] exp_vec();
    logic [1:0] s;
    s = m_state[1:0];
    return {s, m_state == 1, m_state == 2, m_state == 3, m_grst, m_blink};
  endfunction
  task automatic step();
    frame_tick = tick_on && (cycle % 10 == 9);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    cycle++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; tick_on = 0; key_left = 0; key_right = 0; player_fell = 0;
    step(); step();
    rst = 0;
    step();
    tick_on = 1;
  endtask
  task automatic test_reset();
    int nt;
    rst = 1; tick_on = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== 7'd0) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 7'd0); end
    end
    rst = 0;
    step();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL startup_edge1 state=%0d exp=1", state); end
    step();
    checks++;
    if (state !== 2'd1 || start_en !== 1'b1)
      begin errors++; $display("FAIL startup_edge2 state=%0d start_en=%b exp 1/1", state, start_en); end
    tick_on = 1; nt = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (frame_tick) nt++;
      checks++;
      if (text_blink !== 1'((nt / BH) % 2 == 0))
        begin errors++; $display("FAIL blink_phase ticks=%0d blink=%b", nt, text_blink); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_model obs=%b exp=%b", obs, exp_vec()); end
    end
  endtask
  task automatic test_early_press();
    int nt, guard;
    do_reset();
    nt = 0; guard = 0;
    while (nt < 2 && guard < 100) begin step(); if (frame_tick) nt++; guard++; end
    key_right = 1;
    while (nt < 7 && guard < 200) begin
      if (nt == 6) key_right = 0;
      step();
      if (frame_tick) nt++;
      guard++;
      checks++;
      if (state !== 2'd1) begin errors++; $display("FAIL early_press_state state=%0d exp=1", state); end
    end
    checks++;
    if (guard >= 200) begin errors++; $display("FAIL early_press_timeout ticks=%0d exp=7", nt); end
    key_right = 1;
    step();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL press_latency1 state=%0d exp=1", state); end
    step();
    checks++;
    if ({state, start_en, game_en, game_rst} !== 5'b10011)
      begin errors++; $display("FAIL press_enter_play got=%b exp=%b", {state, start_en, game_en, game_rst}, 5'b10011); end
    step();
    checks++;
    if (game_en !== 1'b1 || game_rst !== 1'b0)
      begin errors++; $display("FAIL game_rst_width game_en=%b game_rst=%b exp 1/0", game_en, game_rst); end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL early_model obs=%b exp=%b", obs, exp_vec()); end
  endtask
  task automatic test_fall();
    int nt, guard;
    key_right = 0;
    step(); step();
    player_fell = 1;
    step();
    player_fell = 0;
    checks++;
    if ({state, game_en, over_en} !== 4'b1101)
      begin errors++; $display("FAIL fall_to_over got=%b exp=%b", {state, game_en, over_en}, 4'b1101); end
    nt = 0; guard = 0;
    while (nt < OH && guard < 100) begin
      key_left = 1'($urandom_range(0, 1));
      step();
      if (frame_tick) nt++;
      guard++;
      checks++;
      if (nt < OH && state !== 2'd3) begin errors++; $display("FAIL over_hold state=%0d ticks=%0d exp=3", state, nt); end
      else if (nt == OH && (state !== 2'd1 || start_en !== 1'b1))
        begin errors++; $display("FAIL over_return state=%0d start_en=%b exp 1/1", state, start_en); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL over_model obs=%b exp=%b", obs, exp_vec()); end
    end
    key_left = 0;
    checks++;
    if (guard >= 100) begin errors++; $display("FAIL over_timeout ticks=%0d exp=%0d", nt, OH); end
  endtask
  task automatic test_simultaneous();
    int nt, guard;
    nt = 0; guard = 0;
    while (nt < SH && guard < 100) begin step(); if (frame_tick) nt++; guard++; end
    key_left = 1;
    step(); step();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL simul_enter_play state=%0d exp=2", state); end
    key_left = 0;
    step(); step();
    key_left = 1;
    step();
    player_fell = 1;
    step();
    player_fell = 0;
    checks++;
    if (state !== 2'd3 || over_en !== 1'b1)
      begin errors++; $display("FAIL simul_fall_press state=%0d over_en=%b exp 3/1", state, over_en); end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL simul_model obs=%b exp=%b", obs, exp_vec()); end
    key_left = 0;
  endtask
  task automatic test_async_rst();
    step();
    checks++;
    if (over_en !== 1'b1) begin errors++; $display("FAIL async_pre over_en=%b exp=1", over_en); end
    #2 rst = 1;
    #1;
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL async_clear obs=%b exp=%b", obs, 7'd0); end
    model_reset();
    @(negedge clk);
    step();
    rst = 0;
    step();
    checks++;
    if (state !== 2'd1 || start_en !== 1'b1)
      begin errors++; $display("FAIL async_restart state=%0d start_en=%b exp 1/1", state, start_en); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) key_left = ~key_left;
      if ($urandom_range(0, 11) == 0) key_right = ~key_right;
      player_fell = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_model cyc=%0d obs=%b exp=%b", i, obs, exp_vec()); end
      checks++;
      if ($countones({start_en, game_en, over_en}) > 1)
        begin errors++; $display("FAIL enable_onehot got=%b exp at most one", {start_en, game_en, over_en}); end
    end
    player_fell = 0; key_left = 0; key_right = 0;
  endtask
  task automatic test_saturation();
    int nt, guard;
    do_reset();
    nt = 0; guard = 0;
    while (nt < 254 && guard < 3000) begin step(); if (frame_tick) nt++; guard++; end
    key_right = 1;
    step(); step(); step();
    checks++;
    if (s_state !== 2'd1) begin errors++; $display("FAIL sat_early_press state=%0d exp=1", s_state); end
    key_right = 0;
    while (nt < 300 && guard < 4000) begin step(); if (frame_tick) nt++; guard++; end
    checks++;
    if (guard >= 4000) begin errors++; $display("FAIL sat_timeout ticks=%0d exp=300", nt); end
    checks++;
    if (dut_sat.frame_cnt !== 8'd255) begin errors++; $display("FAIL sat_count cnt=%0d exp=255", dut_sat.frame_cnt); end
    checks++;
    if (s_state !== 2'd1) begin errors++; $display("FAIL sat_hold_state state=%0d exp=1", s_state); end
    key_right = 1;
    step(); step();
    checks++;
    if (s_state !== 2'd2 || s_game_en !== 1'b1)
      begin errors++; $display("FAIL sat_press state=%0d game_en=%b exp 2/1", s_state, s_game_en); end
    key_right = 0;
  endtask
  initial begin
    model_reset();
    test_reset();
    test_early_press();
    test_fall();
    test_simultaneous();
    test_async_rst();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
